// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one UART transmitter among N byte-stream requesters.
// A grant is held for a whole packet; an optional channel-header byte leads each packet.
module uart_tx_arb #(
    parameter int         N         = 4,
    parameter int         ID_W      = 2,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [4:0] HDR_TAG   = 5'b10100,
    parameter int         STALL_MAX = 255
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic [N-1:0]    req_valid,
    input  logic [8*N-1:0]  req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    input  logic            busy_tx,
    output logic            transmit,
    output logic [7:0]      data_tx,
    output logic [ID_W-1:0] grant_id,
    output logic            active,
    output logic            abort
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_BUSY, WAIT_IDLE} state_t;
    state_t state, state_nx;

    logic [ID_W-1:0] ptr;
    logic            hdr_pend;
    logic            last;
    logic [7:0]      stall_cnt;

    logic [ID_W-1:0] winner;
    logic            any_req;
    int              idx;
    logic            g_valid;
    logic [7:0]      g_data;
    logic            g_last;
    logic [7:0]      hdr_byte;
    logic            stall_hit;

    // Scan from the slot after the previous grantee; first hit wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_req && req_valid[idx]) begin
                winner  = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign g_valid   = req_valid[grant_id];
    assign g_data    = req_data[int'(grant_id)*8 +: 8];
    assign g_last    = req_last[grant_id];
    assign hdr_byte  = {HDR_TAG, 3'(grant_id)};
    assign stall_hit = (stall_cnt == 8'(STALL_MAX - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        transmit  = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_req) state_nx = FETCH;
            end
            FETCH: begin
                if (hdr_pend) begin
                    state_nx = ISSUE;
                end else if (g_valid) begin
                    req_ready[grant_id] = 1'b1;
                    state_nx            = ISSUE;
                end else if (stall_hit) begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                transmit = 1'b1;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_tx) state_nx = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!busy_tx) state_nx = last ? IDLE : FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ptr       <= ID_W'(N - 1);
            grant_id  <= '0;
            active    <= 1'b0;
            hdr_pend  <= 1'b0;
            last      <= 1'b0;
            stall_cnt <= '0;
            data_tx   <= '0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id  <= winner;
                        active    <= 1'b1;
                        hdr_pend  <= HDR_EN;
                        stall_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (hdr_pend) begin
                        data_tx  <= hdr_byte;
                        hdr_pend <= 1'b0;
                        last     <= 1'b0;
                    end else if (g_valid) begin
                        data_tx   <= g_data;
                        last      <= g_last;
                        stall_cnt <= '0;
                    end else if (stall_hit) begin
                        // Drop the stalled packet; the grantee goes to the back of the rotation.
                        abort     <= 1'b1;
                        active    <= 1'b0;
                        ptr       <= grant_id;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (!busy_tx && last) begin
                        active <= 1'b0;
                        ptr    <= grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: scripted requesters and a UART busy model, two DUT configurations.
module tb_uart_tx_arb;
    localparam int N        = 4;
    localparam int BUSY_LEN = 3;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           busy_tx, transmit, active, abort;
    logic [7:0]     data_tx;
    logic [1:0]     grant_id;

    logic [N-1:0]   b_req_valid, b_req_last, b_req_ready;
    logic [8*N-1:0] b_req_data;
    logic           b_busy_tx, b_transmit, b_active, b_abort;
    logic [7:0]     b_data_tx;
    logic [1:0]     b_grant_id;

    uart_tx_arb #(.N(N), .ID_W(2), .HDR_EN(1'b1), .HDR_TAG(5'b10100), .STALL_MAX(10)) dut (
        .clk(clk), .nRst(nRst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .busy_tx(busy_tx), .transmit(transmit), .data_tx(data_tx),
        .grant_id(grant_id), .active(active), .abort(abort));

    uart_tx_arb #(.N(N), .ID_W(2), .HDR_EN(1'b0), .HDR_TAG(5'b10100), .STALL_MAX(255)) dut_b (
        .clk(clk), .nRst(nRst), .req_valid(b_req_valid), .req_data(b_req_data), .req_last(b_req_last),
        .req_ready(b_req_ready), .busy_tx(b_busy_tx), .transmit(b_transmit), .data_tx(b_data_tx),
        .grant_id(b_grant_id), .active(b_active), .abort(b_abort));

    // UART model: busy for BUSY_LEN cycles starting the cycle after transmit.
    int busy_cnt, b_busy_cnt;
    always @(posedge clk or negedge nRst) begin
        if (!nRst)               busy_cnt <= 0;
        else if (transmit)       busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end
    always @(posedge clk or negedge nRst) begin
        if (!nRst)               b_busy_cnt <= 0;
        else if (b_transmit)     b_busy_cnt <= BUSY_LEN;
        else if (b_busy_cnt != 0) b_busy_cnt <= b_busy_cnt - 1;
    end
    assign busy_tx   = (busy_cnt != 0);
    assign b_busy_tx = (b_busy_cnt != 0);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] src_byte [N][8];
    bit         src_last [N][8];
    int         src_len  [N];
    int         src_pos  [N];
    int         src_stop [N];

    logic [7:0] tx_log [$];
    int         tx_cyc [$];
    int         hs_log [$];
    int         hs_cnt [N];
    int         rdy_cnt [N];
    int         fall_cnt, last_fall, act_fall, abort_cnt, abort_cyc;
    logic       abort_act, prev_busy, prev_act;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            int p = src_pos[i];
            req_valid[i]       = (p < src_len[i]) && (p != src_stop[i]);
            req_data[8*i +: 8] = (p < 8) ? src_byte[i][p] : 8'h00;
            req_last[i]        = (p < 8) ? src_last[i][p] : 1'b0;
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_pos[i]  = 0;
            src_stop[i] = -1;
        end
    endtask

    task automatic add_byte(input int i, input logic [7:0] b, input bit l);
        src_byte[i][src_len[i]] = b;
        src_last[i][src_len[i]] = l;
        src_len[i]++;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        tx_cyc.delete();
        hs_log.delete();
        for (int i = 0; i < N; i++) begin
            hs_cnt[i]  = 0;
            rdy_cnt[i] = 0;
        end
        fall_cnt  = 0;
        last_fall = -1;
        act_fall  = -1;
        abort_cnt = 0;
        abort_cyc = -1;
        abort_act = 1'b1;
        prev_busy = busy_tx;
        prev_act  = active;
    endtask

    // One clock: observe at negedge, then update requesters just after the posedge.
    task automatic step();
        logic [N-1:0] hs, gmask;
        @(negedge clk);
        hs    = req_valid & req_ready;
        gmask = '0;
        gmask[grant_id] = 1'b1;
        if (transmit) begin
            tx_log.push_back(data_tx);
            tx_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                hs_log.push_back(i);
                hs_cnt[i]++;
            end
            if (req_ready[i]) rdy_cnt[i]++;
        end
        checks++; if ((req_ready & ~gmask) !== '0) begin errors++; $display("FAIL ready_grant: req_ready=%b grant_id=%0d at cycle %0d", req_ready, grant_id, cyc); end
        if (prev_busy && !busy_tx) begin
            fall_cnt++;
            last_fall = cyc;
        end
        prev_busy = busy_tx;
        if (prev_act && !active) act_fall = cyc;
        prev_act = active;
        if (abort) begin
            abort_cnt++;
            abort_cyc = cyc;
            abort_act = active;
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) src_pos[i]++;
        drive_inputs();
    endtask

    task automatic apply_reset();
        nRst = 1'b0;
        clear_src();
        drive_inputs();
        b_req_valid = '0; b_req_data = '0; b_req_last = '0;
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1 nRst = 1'b1;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        clear_src();
        drive_inputs();
        b_req_valid = '0; b_req_data = '0; b_req_last = '0;
        @(negedge clk);
        checks++; if (transmit !== 1'b0)  begin errors++; $display("FAIL reset_transmit: got %b want 0", transmit); end
        checks++; if (data_tx !== 8'h00)  begin errors++; $display("FAIL reset_data_tx: got %h want 00", data_tx); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (grant_id !== 2'd0)  begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (active !== 1'b0)    begin errors++; $display("FAIL reset_active: got %b want 0", active); end
        checks++; if (abort !== 1'b0)     begin errors++; $display("FAIL reset_abort: got %b want 0", abort); end
        checks++; if (b_transmit !== 1'b0 || b_req_ready !== 4'b0 || b_active !== 1'b0) begin errors++; $display("FAIL reset_dut_b: transmit=%b req_ready=%b active=%b want 0", b_transmit, b_req_ready, b_active); end
        @(posedge clk); cyc++;
        #1 nRst = 1'b1;
    endtask

    task automatic test_single_packet();
        int t0;
        apply_reset();
        clear_logs();
        add_byte(2, 8'h55, 1'b0);
        add_byte(2, 8'hAA, 1'b1);
        drive_inputs();
        t0 = cyc;
        for (int k = 0; k < 200 && act_fall < 0; k++) step();
        checks++; if (act_fall < 0) begin errors++; $display("FAIL single_timeout: active never fell, got %0d want >=0", act_fall); end
        checks++; if (tx_log.size() != 3) begin errors++; $display("FAIL single_count: got %0d bytes want 3", tx_log.size()); end
        if (tx_log.size() == 3) begin
            checks++; if (tx_log[0] !== 8'hA2) begin errors++; $display("FAIL single_hdr: got %h want a2", tx_log[0]); end
            checks++; if (tx_log[1] !== 8'h55) begin errors++; $display("FAIL single_b0: got %h want 55", tx_log[1]); end
            checks++; if (tx_log[2] !== 8'hAA) begin errors++; $display("FAIL single_b1: got %h want aa", tx_log[2]); end
            checks++; if (tx_cyc[0] != t0 + 2) begin errors++; $display("FAIL hdr_latency: got cycle %0d want %0d", tx_cyc[0], t0 + 2); end
            checks++; if (tx_cyc[1] - tx_cyc[0] != 6) begin errors++; $display("FAIL b2b_gap: got %0d want 6", tx_cyc[1] - tx_cyc[0]); end
        end
        checks++; if (rdy_cnt[2] != 2) begin errors++; $display("FAIL single_ready_cycles: got %0d want 2", rdy_cnt[2]); end
        checks++; if (rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3] != 0) begin errors++; $display("FAIL single_other_ready: got %0d want 0", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3]); end
        checks++; if (fall_cnt != 3) begin errors++; $display("FAIL single_busy_drops: got %0d want 3", fall_cnt); end
        checks++; if (act_fall != last_fall + 1) begin errors++; $display("FAIL single_active_fall: got cycle %0d want %0d", act_fall, last_fall + 1); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
    endtask

    task automatic test_contention();
        apply_reset();
        clear_logs();
        for (int i = 0; i < N; i++) begin
            add_byte(i, 8'(i * 16), 1'b1);
            add_byte(i, 8'(i * 16 + 1), 1'b1);
        end
        drive_inputs();
        for (int k = 0; k < 400 && (hs_log.size() < 8 || active); k++) step();
        checks++; if (hs_log.size() != 8) begin errors++; $display("FAIL rr_count: got %0d grants want 8", hs_log.size()); end
        for (int k = 0; k < 8; k++) begin
            int got = (k < hs_log.size()) ? hs_log[k] : -1;
            checks++; if (got != k % 4) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, got, k % 4); end
        end
        if (tx_log.size() == 16) begin
            checks++; if (tx_log[8] !== 8'hA0) begin errors++; $display("FAIL rr_hdr_wrap: got %h want a0", tx_log[8]); end
            checks++; if (tx_log[9] !== 8'h01) begin errors++; $display("FAIL rr_data_wrap: got %h want 01", tx_log[9]); end
        end else begin
            checks++; errors++; $display("FAIL rr_tx_count: got %0d want 16", tx_log.size());
        end
    endtask

    task automatic test_packet_lock();
        int exp_lock [4] = '{1, 1, 1, 0};
        apply_reset();
        clear_logs();
        add_byte(1, 8'h11, 1'b0);
        add_byte(1, 8'h12, 1'b0);
        add_byte(1, 8'h13, 1'b1);
        drive_inputs();
        step();
        add_byte(0, 8'h0F, 1'b1);
        drive_inputs();
        for (int k = 0; k < 300 && (hs_log.size() < 4 || active); k++) step();
        for (int k = 0; k < 4; k++) begin
            int got = (k < hs_log.size()) ? hs_log[k] : -1;
            checks++; if (got != exp_lock[k]) begin errors++; $display("FAIL lock_order[%0d]: got %0d want %0d", k, got, exp_lock[k]); end
        end
        checks++; if (tx_log.size() != 6 || tx_log[3] !== 8'h13 || tx_log[4] !== 8'hA0) begin errors++; $display("FAIL lock_stream: size %0d, want 6 with a0 after 13", tx_log.size()); end
    endtask

    task automatic test_stall_abort();
        int exp_after [3] = '{0, 2, 3};
        apply_reset();
        clear_logs();
        add_byte(3, 8'h31, 1'b0);
        add_byte(3, 8'h32, 1'b1);
        src_stop[3] = 1;
        drive_inputs();
        for (int k = 0; k < 100 && abort_cnt == 0; k++) step();
        checks++; if (abort_cnt == 0) begin errors++; $display("FAIL stall_timeout: abort count %0d want 1", abort_cnt); end
        checks++; if (abort_cyc != last_fall + 11) begin errors++; $display("FAIL stall_timing: abort at %0d want %0d", abort_cyc, last_fall + 11); end
        checks++; if (abort_act !== 1'b0) begin errors++; $display("FAIL stall_active: got %b want 0 with abort", abort_act); end
        checks++; if (tx_log.size() != 2) begin errors++; $display("FAIL stall_tx_count: got %0d want 2", tx_log.size()); end
        src_stop[3] = -1;
        add_byte(0, 8'h01, 1'b1);
        add_byte(2, 8'h21, 1'b1);
        drive_inputs();
        for (int k = 0; k < 300 && (hs_log.size() < 4 || active); k++) step();
        for (int k = 0; k < 3; k++) begin
            int got = (k + 1 < hs_log.size()) ? hs_log[k + 1] : -1;
            checks++; if (got != exp_after[k]) begin errors++; $display("FAIL stall_rr[%0d]: got %0d want %0d", k, got, exp_after[k]); end
        end
        checks++; if (abort_cnt != 1) begin errors++; $display("FAIL stall_pulse: got %0d abort cycles want 1", abort_cnt); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        clear_logs();
        add_byte(1, 8'h44, 1'b0);
        add_byte(1, 8'h45, 1'b1);
        drive_inputs();
        for (int k = 0; k < 20 && tx_log.size() == 0; k++) step();
        step();
        checks++; if (active !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL mid_pre: active=%b grant=%0d want 1/1", active, grant_id); end
        nRst = 1'b0;
        #1;
        checks++; if (transmit !== 1'b0)  begin errors++; $display("FAIL mid_transmit: got %b want 0", transmit); end
        checks++; if (data_tx !== 8'h00)  begin errors++; $display("FAIL mid_data_tx: got %h want 00", data_tx); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL mid_req_ready: got %b want 0000", req_ready); end
        checks++; if (grant_id !== 2'd0)  begin errors++; $display("FAIL mid_grant_id: got %0d want 0", grant_id); end
        checks++; if (active !== 1'b0)    begin errors++; $display("FAIL mid_active: got %b want 0", active); end
        checks++; if (abort !== 1'b0)     begin errors++; $display("FAIL mid_abort: got %b want 0", abort); end
        clear_src();
        for (int i = 0; i < N; i++) add_byte(i, 8'(8'hC0 + i), 1'b1);
        drive_inputs();
        clear_logs();
        @(posedge clk); cyc++;
        #1 nRst = 1'b1;
        step();
        checks++; if (grant_id !== 2'd0 || active !== 1'b1) begin errors++; $display("FAIL mid_first_grant: grant=%0d active=%b want 0/1", grant_id, active); end
        for (int k = 0; k < 300 && (hs_log.size() < 4 || active); k++) step();
        checks++; if (hs_log.size() != 4 || hs_log[0] != 0 || hs_log[3] != 3) begin errors++; $display("FAIL mid_order: %0d grants, want 4 in order 0..3", hs_log.size()); end
    endtask

    task automatic test_latency();
        apply_reset();
        b_req_valid[0]  = 1'b1;
        b_req_data[7:0] = 8'h5A;
        b_req_last[0]   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (b_req_ready[0] !== (k == 1)) begin errors++; $display("FAIL lat_ready t+%0d: got %b want %b", k, b_req_ready[0], k == 1); end
            checks++; if (b_transmit !== (k == 2))     begin errors++; $display("FAIL lat_transmit t+%0d: got %b want %b", k, b_transmit, k == 2); end
            if (k == 2) begin
                checks++; if (b_data_tx !== 8'h5A) begin errors++; $display("FAIL lat_data: got %h want 5a", b_data_tx); end
            end
            @(posedge clk); cyc++;
            #1;
            if (k == 1) b_req_valid[0] = 1'b0;
        end
        for (int k = 0; k < 50 && b_active; k++) begin
            @(posedge clk); cyc++;
            #1;
        end
        checks++; if (b_active !== 1'b0) begin errors++; $display("FAIL lat_done: active=%b want 0", b_active); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        clear_src();
        drive_inputs();
        b_req_valid = '0; b_req_data = '0; b_req_last = '0;
        test_reset();
        test_single_packet();
        test_contention();
        test_packet_lock();
        test_stall_abort();
        test_reset_mid();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
